// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Purpose  : Shared types and constants for the PIC host-side sequencer:
//            FSM state encoding, command byte constants, A0 encodings and
//            the write-byte selector used to walk the ICW/OCW1 sequence.
// Revision : 1.0  initial release
// ============================================================================
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    A_PULSE1 = 3'd4,
    A_GAP    = 3'd5,
    A_PULSE2 = 3'd6,
    A_DONE   = 3'd7
  } pic_state_t;

  localparam logic [7:0] OCW2_NS_EOI   = 8'h20;
  localparam int         ICW1_SNGL_BIT = 1;
  localparam int         ICW1_IC4_BIT  = 0;

  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  // Which byte the current write cycle carries
  localparam logic [2:0] SEL_ICW1 = 3'd0;
  localparam logic [2:0] SEL_ICW2 = 3'd1;
  localparam logic [2:0] SEL_ICW3 = 3'd2;
  localparam logic [2:0] SEL_ICW4 = 3'd3;
  localparam logic [2:0] SEL_OCW1 = 3'd4;
  localparam logic [2:0] SEL_EOI  = 3'd5;

  // Next init byte after 'cur'; ICW3 only in cascade mode, ICW4 only when IC4 is set
  function automatic logic [2:0] next_init_sel(input logic [2:0] cur, input logic [7:0] icw1);
    logic [2:0] nxt;
    nxt = SEL_OCW1;
    case (cur)
      SEL_ICW1: nxt = SEL_ICW2;
      SEL_ICW2: begin
        if (!icw1[ICW1_SNGL_BIT])     nxt = SEL_ICW3;
        else if (icw1[ICW1_IC4_BIT])  nxt = SEL_ICW4;
        else                          nxt = SEL_OCW1;
      end
      SEL_ICW3: nxt = icw1[ICW1_IC4_BIT] ? SEL_ICW4 : SEL_OCW1;
      default:  nxt = SEL_OCW1;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_strobe_timer.sv
`default_nettype none
// ============================================================================
// Module   : pic_strobe_timer
// Purpose  : Loadable down-counter timing strobe and gap phases. Loading N
//            makes 'done' high on the Nth clock after the load edge.
// Revision : 1.0  initial release
// ============================================================================
module pic_strobe_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] r_cnt;

  // Count down from the loaded value, resting at zero
  always_ff @(posedge clk) begin
    if (!reset_n)            r_cnt <= '0;
    else if (load)           r_cnt <= load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign done = (r_cnt == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pic_host_sequencer
// Purpose  : Host bus master for an 8259A-style PIC: ICW/OCW1 init writes,
//            non-specific EOI writes and two-pulse INTA vector capture with a
//            valid/ready vector handshake.
// Options  : PIC_HOST_AUTO_EOI_EN - vector acceptance queues an automatic EOI.
// Revision : 1.0  initial release
// ============================================================================
module pic_host_sequencer
  import pic_pkg::*;
#(
  parameter int         STROBE_CYCLES = 2,
  parameter int         GAP_CYCLES    = 2,
  parameter logic [7:0] ICW1_VAL      = 8'h13,
  parameter logic [7:0] ICW2_VAL      = 8'h20,
  parameter logic [7:0] ICW3_VAL      = 8'h00,
  parameter logic [7:0] ICW4_VAL      = 8'h01
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_start,
  input  logic [7:0] imr_mask,
  output logic       init_busy,
  output logic       init_done,
  input  logic       eoi_req,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic [7:0] vec_data,
  input  logic       INT,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       A0,
  output logic       INTA,
  output logic [7:0] input_data_bus,
  input  logic [7:0] output_data_bus
);

  pic_state_t r_state, w_next_state;
  logic [2:0] r_sel, w_next_sel;
  logic       r_init_pend, r_init_busy, r_init_done, r_eoi_pend;
  logic [7:0] r_mask;
  logic       r_vec_valid;
  logic [7:0] r_vec_data;

  logic       w_tmr_done, w_tmr_load;
  logic [7:0] w_tmr_val;
  logic       w_sel_a0;
  logic [7:0] w_sel_data;
  logic       w_auto_eoi;

  // A fresh init_start is taken in the same clock so IDLE can start ICW1 at once
  wire w_init_accept = init_start & ~r_init_busy;
  wire w_init_any    = r_init_pend | w_init_accept;
  wire w_eoi_any     = (r_eoi_pend | eoi_req) & r_init_done;
  wire w_in_idle     = (r_state == IDLE);
  wire w_init_go     = w_in_idle & w_init_any;
  wire w_eoi_go      = w_in_idle & ~w_init_any & w_eoi_any;
  wire w_ack_go      = w_in_idle & ~w_init_any & ~w_eoi_any & INT & r_init_done & ~r_vec_valid;
  wire w_init_finish = (r_state == W_HOLD) && (r_sel == SEL_OCW1);
  wire w_vec_accept  = r_vec_valid & vec_ready;

`ifdef PIC_HOST_AUTO_EOI_EN
  assign w_auto_eoi = w_vec_accept;
`else
  assign w_auto_eoi = 1'b0;
`endif

  // Reload the timer on entry to every timed phase
  assign w_tmr_load = (w_next_state != r_state) &&
                      (w_next_state == W_STROBE || w_next_state == A_PULSE1 ||
                       w_next_state == A_GAP    || w_next_state == A_PULSE2);
  assign w_tmr_val  = (w_next_state == A_GAP) ? 8'(GAP_CYCLES) : 8'(STROBE_CYCLES);

  pic_strobe_timer #(.WIDTH(8)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .done     (w_tmr_done)
  );

  // State register and byte selector
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sel   <= SEL_ICW1;
    end else begin
      r_state <= w_next_state;
      r_sel   <= w_next_sel;
    end
  end

  // Next-state logic with IDLE arbitration: init > EOI > acknowledge
  always_comb begin
    w_next_state = r_state;
    w_next_sel   = r_sel;
    case (r_state)
      IDLE: begin
        if (w_init_go) begin
          w_next_state = W_SETUP;
          w_next_sel   = SEL_ICW1;
        end else if (w_eoi_go) begin
          w_next_state = W_SETUP;
          w_next_sel   = SEL_EOI;
        end else if (w_ack_go) begin
          w_next_state = A_PULSE1;
        end
      end
      W_SETUP:  w_next_state = W_STROBE;
      W_STROBE: if (w_tmr_done) w_next_state = W_HOLD;
      W_HOLD: begin
        // Init bytes chain back-to-back; OCW1 and EOI return to IDLE
        if (r_sel < SEL_OCW1) begin
          w_next_state = W_SETUP;
          w_next_sel   = next_init_sel(r_sel, ICW1_VAL);
        end else begin
          w_next_state = IDLE;
        end
      end
      A_PULSE1: if (w_tmr_done) w_next_state = A_GAP;
      A_GAP:    if (w_tmr_done) w_next_state = A_PULSE2;
      A_PULSE2: if (w_tmr_done) w_next_state = A_DONE;
      A_DONE:   w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Decode the register select and data byte for the current write
  always_comb begin
    w_sel_a0   = A0_DATA;
    w_sel_data = 8'h00;
    case (r_sel)
      SEL_ICW1: begin w_sel_a0 = A0_CMD;  w_sel_data = ICW1_VAL;    end
      SEL_ICW2: begin w_sel_a0 = A0_DATA; w_sel_data = ICW2_VAL;    end
      SEL_ICW3: begin w_sel_a0 = A0_DATA; w_sel_data = ICW3_VAL;    end
      SEL_ICW4: begin w_sel_a0 = A0_DATA; w_sel_data = ICW4_VAL;    end
      SEL_OCW1: begin w_sel_a0 = A0_DATA; w_sel_data = r_mask;      end
      SEL_EOI:  begin w_sel_a0 = A0_CMD;  w_sel_data = OCW2_NS_EOI; end
      default:  begin w_sel_a0 = A0_DATA; w_sel_data = 8'h00;       end
    endcase
  end

  // Bus pin outputs decoded from the current state
  always_comb begin
    CS             = 1'b1;
    WR             = 1'b1;
    RD             = 1'b1;
    A0             = A0_CMD;
    INTA           = 1'b1;
    input_data_bus = 8'h00;
    case (r_state)
      W_SETUP, W_HOLD: begin
        CS             = 1'b0;
        A0             = w_sel_a0;
        input_data_bus = w_sel_data;
      end
      W_STROBE: begin
        CS             = 1'b0;
        WR             = 1'b0;
        A0             = w_sel_a0;
        input_data_bus = w_sel_data;
      end
      A_PULSE1, A_PULSE2: INTA = 1'b0;
      default: ;
    endcase
  end

  // Init/EOI bookkeeping flags and the captured vector
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_init_pend <= 1'b0;
      r_init_busy <= 1'b0;
      r_init_done <= 1'b0;
      r_eoi_pend  <= 1'b0;
      r_mask      <= 8'h00;
      r_vec_valid <= 1'b0;
      r_vec_data  <= 8'h00;
    end else begin
      if (w_init_accept) begin
        r_mask      <= imr_mask;
        r_init_busy <= 1'b1;
        r_init_done <= 1'b0;
      end else if (w_init_finish) begin
        r_init_busy <= 1'b0;
        r_init_done <= 1'b1;
      end
      r_init_pend <= w_init_any & ~w_init_go;

      // EOI requests before init completes are dropped; repeats merge while pending
      if (!r_init_done || w_eoi_go)   r_eoi_pend <= 1'b0;
      else if (eoi_req || w_auto_eoi) r_eoi_pend <= 1'b1;

      if (r_state == A_PULSE2 && w_tmr_done) r_vec_data <= output_data_bus;
      if (r_state == A_DONE)                 r_vec_valid <= 1'b1;
      else if (w_vec_accept)                 r_vec_valid <= 1'b0;
    end
  end

  assign init_busy = r_init_busy;
  assign init_done = r_init_done;
  assign vec_valid = r_vec_valid;
  assign vec_data  = r_vec_data;

endmodule
`default_nettype wire
